deconv2d_mc: RTL and testbench
==============================

Name: deconv2d_mc

Overview:
Multi-channel, parametrised transposed-convolution (deconvolution) engine. It takes C input feature maps of N×N pixels, each with its own runtime-sized kernel (up to K×K). It scatter-accumulates every pixel×weight product into one shared output map of up to (N·K)×(N·K) words. Kernel and pixel inputs use valid/ready stream handshakes, and results are read back through a registered address port once done pulses. This block succeeds the single-channel, strobe-driven deconvolution unit in the upsampling path.

Parameters:
N, 2, input map width/height in pixels
K, 3, maximum kernel width; also the maximum stride
C_MAX, 4, maximum number of input channels
PIXEL_BITS, 8, unsigned pixel and weight width
ACC_BITS, 32, unsigned accumulator/result width; must be >= 2·PIXEL_BITS

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a job; sampled in IDLE only
stride  in  $clog2(K+1)  output step per input pixel, legal 1..K; sampled at start
kernel_width  in  $clog2(K+1)  kernel width kw, legal 1..K; sampled at start
num_channels  in  $clog2(C_MAX+1)  channel count nc, legal 1..C_MAX; sampled at start
k_valid  in  1  kernel weight valid
k_ready  out  1  high only in LOAD_KERNEL
k_data  in  PIXEL_BITS  kernel weight, row-major within kw×kw
p_valid  in  1  pixel valid
p_ready  out  1  high only in WAIT_PIX
p_data  in  PIXEL_BITS  pixel, raster order r=0..N-1, c=0..N-1
rd_addr  in  $clog2(N*K*N*K)  result address = row·(N·K)+col
rd_data  out  ACC_BITS  result word, registered, one-cycle read latency
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion
err  out  1  one-cycle pulse when start carries an illegal config

Behaviour:
- Reset (asynchronous): state=IDLE; busy, done, err, k_ready, p_ready = 0; rd_data=0; all counters and latched config = 0. Result RAM contents are not reset.
- IDLE: on start with a legal config, latch stride, kw and nc, zero all counters and go to CLEAR. If stride, kw or nc is 0 or out of range, pulse err for one cycle and stay in IDLE. start outside IDLE is ignored.
- CLEAR: write 0 to one RAM word per cycle, addresses 0..(N·K)²−1 ascending. This takes exactly (N·K)² cycles, then go to LOAD_KERNEL with ch=0.
- LOAD_KERNEL: each k_valid&&k_ready handshake stores the weight at kernel slot (w/kw)·K + w%kw, with w = 0..kw²−1. Slots outside kw×kw are held at 0. After the kw²-th handshake, go to WAIT_PIX with pixel index p=0.
- WAIT_PIX: a p_valid&&p_ready handshake registers the pixel together with r=p/N and c=p%N, then goes to ACCUM with tap t=0. Gaps in p_valid stall the engine without loss.
- ACCUM: one tap per cycle for t = 0..kw²−1, with ki=t/kw and kj=t%kw.
  - Target address is (r·stride+ki)·(N·K) + (c·stride+kj).
  - Update RAM[addr] ← sat(RAM[addr] + pixel·w[ki][kj]).
  - The stage takes kw² cycles per pixel.
- After ACCUM:
  - If p<N²−1: p++ and return to WAIT_PIX.
  - Else if ch<nc−1: ch++ and return to LOAD_KERNEL; the new kernel replaces the old one and RAM is not cleared.
  - Else go to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- Arithmetic: all values are unsigned. Each product is 2·PIXEL_BITS wide and zero-extended to ACC_BITS. sat() clamps to 2^ACC_BITS−1 and never wraps; a clamped word stays clamped through later additions.
- Output extent: active output is (N−1)·stride+kw square. Words outside that region remain 0.
- Read port: rd_data ← RAM[rd_addr] every cycle, with rd_data valid the cycle after rd_addr is presented. The contents are defined only while busy=0 after done. Reads during busy return unspecified data but must not disturb accumulation.
- Reset mid-job: immediate return to IDLE. The next start re-clears the RAM, so no residue from the aborted job survives.
- At most one RAM write per cycle. Read-during-write to the same address returns the old value.

Test Plan:
- N=2, K=3, stride=1, kw=3, nc=1, all-ones kernel, pixels 1,2,3,4 → row 0 = 1,3,3,2; row 1 = 4,10,10,6; row 3 = 3,7,7,4. Words at col ≥4 stay 0 and done pulses once.
- stride=3, kw=3, nc=1, kernel 1..9, pixels 1,2,3,4 → non-overlapping 6×6 map; RAM[0]=1, RAM[3]=2, RAM[35]=4·9=36.
- nc=2 with the same kernel and pixels as the first scenario on both channels → every word doubles (centre words = 20). k_ready reasserts after the first channel's 4th pixel.
- ACC_BITS=16, nc=4, pixel=255 and weight=255 everywhere, stride=1, kw=3 → centre words clamp to 65535 with no wrap; corner word = 4·65025 clamped = 65535.
- p_valid toggled on alternate cycles, k_valid held low for 5 cycles mid-kernel → identical results to the first scenario. p_ready is never high outside WAIT_PIX.
- Assert rst during ACCUM, then start a fresh job with kw=2 → busy drops asynchronously and the second job's results contain no residue. A separate start with stride=0 → err pulses for one cycle and busy stays 0.

Source files
------------

// File: rtl/deconv2d_mc.sv
// Multi-channel transposed-convolution engine: scatter-accumulates pixel x weight
// products from C kernels into one saturating (N*K)^2 result RAM.
module deconv2d_mc #(
  parameter int N          = 2,
  parameter int K          = 3,
  parameter int C_MAX      = 4,
  parameter int PIXEL_BITS = 8,
  parameter int ACC_BITS   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(K+1)-1:0]         stride,
  input  logic [$clog2(K+1)-1:0]         kernel_width,
  input  logic [$clog2(C_MAX+1)-1:0]     num_channels,
  input  logic                           k_valid,
  output logic                           k_ready,
  input  logic [PIXEL_BITS-1:0]          k_data,
  input  logic                           p_valid,
  output logic                           p_ready,
  input  logic [PIXEL_BITS-1:0]          p_data,
  input  logic [$clog2(N*K*N*K)-1:0]     rd_addr,
  output logic [ACC_BITS-1:0]            rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);
  localparam int SW    = $clog2(K+1);
  localparam int CHW   = $clog2(C_MAX+1);
  localparam int PW    = $clog2(N+1);
  localparam int NK    = N*K;
  localparam int DEPTH = NK*NK;
  localparam int AW    = $clog2(DEPTH);
  localparam int KAW   = $clog2(K*K);
  localparam int PRW   = 2*PIXEL_BITS;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_WAIT, S_ACCUM, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [SW-1:0]         r_stride, r_kw, r_kr, r_kc, r_ki, r_kj;
  logic [CHW-1:0]        r_nc, r_ch;
  logic [PW-1:0]         r_pr, r_pc;
  logic [AW-1:0]         r_clr;
  logic                  r_err;
  logic [PIXEL_BITS-1:0] r_pix;
  logic [PIXEL_BITS-1:0] r_kern [K*K];
  logic [ACC_BITS-1:0]   r_ram [DEPTH];
  logic [ACC_BITS-1:0]   r_rd_data;

  logic            w_cfg_ok, w_clr_last, w_k_last, w_tap_last, w_pix_last, w_ch_last;
  logic [AW-1:0]   w_addr;
  logic [KAW-1:0]  w_tap_idx, w_slot_idx;
  logic [PRW-1:0]  w_prod;

  // Adds a product and clamps at full scale; a clamped word can never wrap back.
  function automatic logic [ACC_BITS-1:0] sat_add(input logic [ACC_BITS-1:0] a,
                                                  input logic [PRW-1:0] b);
    logic [ACC_BITS:0] s;
    s = {1'b0, a} + (ACC_BITS+1)'(b);
    return s[ACC_BITS] ? '1 : s[ACC_BITS-1:0];
  endfunction

  assign w_cfg_ok   = (stride != '0) && (stride <= SW'(K)) &&
                      (kernel_width != '0) && (kernel_width <= SW'(K)) &&
                      (num_channels != '0) && (num_channels <= CHW'(C_MAX));
  assign w_clr_last = (r_clr == AW'(DEPTH-1));
  assign w_k_last   = (r_kr == r_kw - SW'(1)) && (r_kc == r_kw - SW'(1));
  assign w_tap_last = (r_ki == r_kw - SW'(1)) && (r_kj == r_kw - SW'(1));
  assign w_pix_last = (r_pr == PW'(N-1)) && (r_pc == PW'(N-1));
  assign w_ch_last  = (r_ch == r_nc - CHW'(1));
  assign w_addr     = AW'((32'(r_pr)*32'(r_stride) + 32'(r_ki))*32'(NK) +
                          32'(r_pc)*32'(r_stride) + 32'(r_kj));
  assign w_tap_idx  = KAW'(32'(r_ki)*32'(K) + 32'(r_kj));
  assign w_slot_idx = KAW'(32'(r_kr)*32'(K) + 32'(r_kc));
  assign w_prod     = PRW'(r_pix) * PRW'(r_kern[w_tap_idx]);
  assign rd_data    = r_rd_data;
  assign err        = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && w_cfg_ok) w_next = S_CLEAR;
      S_CLEAR: if (w_clr_last) w_next = S_LOAD;
      S_LOAD:  if (k_valid && w_k_last) w_next = S_WAIT;
      S_WAIT:  if (p_valid) w_next = S_ACCUM;
      S_ACCUM: if (w_tap_last) w_next = !w_pix_last ? S_WAIT : (!w_ch_last ? S_LOAD : S_DONE);
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    k_ready = (r_state == S_LOAD);
    p_ready = (r_state == S_WAIT);
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stride <= '0; r_kw <= '0; r_nc <= '0; r_ch <= '0;
      r_kr <= '0; r_kc <= '0; r_ki <= '0; r_kj <= '0;
      r_pr <= '0; r_pc <= '0; r_clr <= '0; r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          if (w_cfg_ok) begin
            r_stride <= stride; r_kw <= kernel_width; r_nc <= num_channels;
            r_ch <= '0; r_kr <= '0; r_kc <= '0; r_ki <= '0; r_kj <= '0;
            r_pr <= '0; r_pc <= '0; r_clr <= '0;
          end else begin
            r_err <= 1'b1;
          end
        end
        S_CLEAR: r_clr <= r_clr + AW'(1);
        S_LOAD: if (k_valid) begin
          if (w_k_last) begin
            r_kr <= '0; r_kc <= '0; r_pr <= '0; r_pc <= '0;
          end else if (r_kc == r_kw - SW'(1)) begin
            r_kc <= '0; r_kr <= r_kr + SW'(1);
          end else begin
            r_kc <= r_kc + SW'(1);
          end
        end
        S_WAIT: if (p_valid) begin
          r_ki <= '0; r_kj <= '0;
        end
        S_ACCUM: begin
          if (w_tap_last) begin
            r_ki <= '0; r_kj <= '0;
            if (!w_pix_last) begin
              if (r_pc == PW'(N-1)) begin
                r_pc <= '0; r_pr <= r_pr + PW'(1);
              end else begin
                r_pc <= r_pc + PW'(1);
              end
            end else if (!w_ch_last) begin
              r_ch <= r_ch + CHW'(1); r_pr <= '0; r_pc <= '0;
            end
          end else if (r_kj == r_kw - SW'(1)) begin
            r_kj <= '0; r_ki <= r_ki + SW'(1);
          end else begin
            r_kj <= r_kj + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Kernel slots outside kw x kw are zeroed once per job, when the job is accepted.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start && w_cfg_ok) begin
      for (int i = 0; i < K*K; i++) r_kern[i] <= '0;
    end else if (r_state == S_LOAD && k_valid) begin
      r_kern[w_slot_idx] <= k_data;
    end
    if (r_state == S_WAIT && p_valid) r_pix <= p_data;
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR)      r_ram[r_clr]  <= '0;
    else if (r_state == S_ACCUM) r_ram[w_addr] <= sat_add(r_ram[w_addr], w_prod);
  end

  // Independent read port; nonblocking update gives old data on a same-address write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= (32'(rd_addr) < DEPTH) ? r_ram[rd_addr] : '0;
  end
endmodule

// File: tb/tb_deconv2d_mc.sv
// Bench for deconv2d_mc: directed and randomized jobs checked against an array model.
module tb_deconv2d_mc;
  localparam int N = 2, K = 3, C_MAX = 4, PB = 8, NK = N*K, DEPTH = NK*NK;

  logic clk = 1'b0;
  logic rst, start_d, start_s;
  logic [1:0] stride, kernel_width;
  logic [2:0] num_channels;
  logic k_valid, p_valid;
  logic [PB-1:0] k_data, p_data;
  logic [5:0] rd_addr;
  logic d_k_ready, d_p_ready, d_busy, d_done, d_err;
  logic s_k_ready, s_p_ready, s_busy, s_done, s_err;
  logic [31:0] d_rd;
  logic [15:0] s_rd;
  logic m_k_ready, m_p_ready, m_busy, m_done, m_err;
  logic [31:0] m_rd;

  int checks = 0, errors = 0, proto_viol = 0, sel = 0;
  int kern [C_MAX][K*K];
  int pix  [C_MAX][N*N];
  longint exp_map [DEPTH];

  deconv2d_mc #(.N(N), .K(K), .C_MAX(C_MAX), .PIXEL_BITS(PB), .ACC_BITS(32)) u_dut (
    .clk(clk), .rst(rst), .start(start_d), .stride(stride), .kernel_width(kernel_width),
    .num_channels(num_channels), .k_valid(k_valid), .k_ready(d_k_ready), .k_data(k_data),
    .p_valid(p_valid), .p_ready(d_p_ready), .p_data(p_data), .rd_addr(rd_addr),
    .rd_data(d_rd), .busy(d_busy), .done(d_done), .err(d_err));

  deconv2d_mc #(.N(N), .K(K), .C_MAX(C_MAX), .PIXEL_BITS(PB), .ACC_BITS(16)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .stride(stride), .kernel_width(kernel_width),
    .num_channels(num_channels), .k_valid(k_valid), .k_ready(s_k_ready), .k_data(k_data),
    .p_valid(p_valid), .p_ready(s_p_ready), .p_data(p_data), .rd_addr(rd_addr),
    .rd_data(s_rd), .busy(s_busy), .done(s_done), .err(s_err));

  always #5 clk = ~clk;

  always_comb begin
    if (sel == 1) begin
      m_k_ready = s_k_ready; m_p_ready = s_p_ready; m_busy = s_busy;
      m_done = s_done; m_err = s_err; m_rd = {16'b0, s_rd};
    end else begin
      m_k_ready = d_k_ready; m_p_ready = d_p_ready; m_busy = d_busy;
      m_done = d_done; m_err = d_err; m_rd = d_rd;
    end
  end

  // Handshake readies must be exclusive and only appear while a job is running.
  always @(negedge clk) begin
    if (!rst) begin
      if ((d_k_ready && d_p_ready) || (!d_busy && (d_k_ready || d_p_ready || d_done)))
        proto_viol++;
      if ((s_k_ready && s_p_ready) || (!s_busy && (s_k_ready || s_p_ready || s_done)))
        proto_viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: direct scatter of every product over the output map, clamped per add.
  task automatic model(input int s, input int kw, input int nc, input longint maxv);
    for (int a = 0; a < DEPTH; a++) exp_map[a] = 0;
    for (int ch = 0; ch < nc; ch++)
      for (int p = 0; p < N*N; p++)
        for (int ki = 0; ki < kw; ki++)
          for (int kj = 0; kj < kw; kj++) begin
            int a;
            a = ((p / N) * s + ki) * NK + (p % N) * s + kj;
            exp_map[a] = exp_map[a] + longint'(pix[ch][p]) * longint'(kern[ch][ki*kw + kj]);
            if (exp_map[a] > maxv) exp_map[a] = maxv;
          end
  endtask

  task automatic send_k(input int v, input int gap);
    int ok;
    ok = 0;
    repeat (gap) begin @(negedge clk); k_valid = 1'b0; p_valid = 1'b0; end
    for (int g = 0; g < 300 && ok == 0; g++) begin
      @(negedge clk); p_valid = 1'b0; k_valid = 1'b1; k_data = 8'(v);
      ok = int'(m_k_ready);
    end
    chk("k_handshake", 64'(ok), 64'd1);
  endtask

  task automatic send_p(input int v, input int gap);
    int ok;
    ok = 0;
    repeat (gap) begin @(negedge clk); k_valid = 1'b0; p_valid = 1'b0; end
    for (int g = 0; g < 300 && ok == 0; g++) begin
      @(negedge clk); k_valid = 1'b0; p_valid = 1'b1; p_data = 8'(v);
      ok = int'(m_p_ready);
    end
    chk("p_handshake", 64'(ok), 64'd1);
  endtask

  task automatic read_word(input int a, output logic [31:0] v);
    @(negedge clk); rd_addr = 6'(a);
    @(negedge clk); v = m_rd;
  endtask

  task automatic check_map();
    logic [31:0] v;
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, v);
      chk($sformatf("rd[%0d]", a), 64'(v), 64'(exp_map[a]));
    end
  endtask

  task automatic kick(input int which, input int s, input int kw, input int nc);
    sel = which;
    @(negedge clk);
    stride = 2'(s); kernel_width = 2'(kw); num_channels = 3'(nc);
    if (which == 1) start_s = 1'b1; else start_d = 1'b1;
    @(negedge clk); start_s = 1'b0; start_d = 1'b0;
  endtask

  // mode 0: back-to-back, 1: random gaps, 2: pixels on alternate cycles + 5-cycle kernel stall
  task automatic run_job(input int which, input int s, input int kw, input int nc, input int mode);
    int got;
    kick(which, s, kw, nc);
    for (int ch = 0; ch < nc; ch++) begin
      for (int w = 0; w < kw*kw; w++)
        send_k(kern[ch][w], mode == 1 ? int'($urandom_range(0, 2)) : (mode == 2 && w == 4) ? 5 : 0);
      for (int p = 0; p < N*N; p++)
        send_p(pix[ch][p], mode == 1 ? int'($urandom_range(0, 2)) : (mode == 2) ? 1 : 0);
    end
    got = 0;
    for (int g = 0; g < 200 && got == 0; g++) begin
      @(negedge clk); k_valid = 1'b0; p_valid = 1'b0;
      got = int'(m_done);
    end
    chk("done_seen", 64'(got), 64'd1);
    @(negedge clk);
    chk("done_once", 64'(m_done), 64'd0);
    chk("busy_idle", 64'(m_busy), 64'd0);
    model(s, kw, nc, which == 1 ? 64'hFFFF : 64'hFFFF_FFFF);
    check_map();
  endtask

  task automatic fill(input int kmode, input int pmode);
    for (int ch = 0; ch < C_MAX; ch++) begin
      for (int w = 0; w < K*K; w++)
        kern[ch][w] = (kmode == 0) ? 1 : (kmode == 1) ? w + 1 : (kmode == 2) ? 255 : int'($urandom_range(0, 255));
      for (int p = 0; p < N*N; p++)
        pix[ch][p] = (pmode == 0) ? p + 1 : (pmode == 2) ? 255 : int'($urandom_range(0, 255));
    end
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; start_d = 1'b0; start_s = 1'b0; stride = '0; kernel_width = '0;
    num_channels = '0; k_valid = 1'b0; p_valid = 1'b0; k_data = '0; p_data = '0; rd_addr = '0;
    #12;
    chk("rst_busy", 64'(d_busy), 64'd0);
    chk("rst_done", 64'(d_done), 64'd0);
    chk("rst_err", 64'(d_err), 64'd0);
    chk("rst_k_ready", 64'(d_k_ready), 64'd0);
    chk("rst_p_ready", 64'(d_p_ready), 64'd0);
    chk("rst_rd_data", 64'(d_rd), 64'd0);
    @(negedge clk); rst = 1'b0;

    fill(0, 0); run_job(0, 1, 3, 1, 0);
    read_word(7, v);  chk("s1_centre", 64'(v), 64'd10);
    read_word(4, v);  chk("s1_col4", 64'(v), 64'd0);
    read_word(18, v); chk("s1_row3", 64'(v), 64'd3);

    fill(1, 0); run_job(0, 3, 3, 1, 0);
    read_word(0, v);  chk("s2_w0", 64'(v), 64'd1);
    read_word(3, v);  chk("s2_w3", 64'(v), 64'd2);
    read_word(35, v); chk("s2_w35", 64'(v), 64'd36);

    fill(0, 0); run_job(0, 1, 3, 2, 0);
    read_word(7, v);  chk("s3_centre", 64'(v), 64'd20);

    run_job(0, 1, 3, 1, 2);
    read_word(8, v);  chk("s5_centre", 64'(v), 64'd10);

    fill(2, 2); run_job(1, 1, 3, 4, 0);
    read_word(7, v);  chk("sat_centre", 64'(v), 64'd65535);
    read_word(0, v);  chk("sat_corner", 64'(v), 64'd65535);

    kick(0, 0, 3, 1);
    chk("err_pulse", 64'(d_err), 64'd1);
    chk("err_busy", 64'(d_busy), 64'd0);
    @(negedge clk);
    chk("err_clear", 64'(d_err), 64'd0);
    kick(0, 1, 3, 5);
    chk("err_nc", 64'(d_err), 64'd1);
    chk("err_nc_busy", 64'(d_busy), 64'd0);

    fill(3, 3);
    kick(0, 1, 3, 1);
    for (int w = 0; w < 9; w++) send_k(kern[0][w], 0);
    send_p(pix[0][0], 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(d_busy), 64'd0);
    k_valid = 1'b0; p_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd", 64'(d_rd), 64'd0);
    rst = 1'b0;
    fill(3, 3); run_job(0, 1, 2, int'($urandom_range(1, 4)), 1);

    for (int it = 0; it < 6; it++) begin
      fill(3, 3);
      run_job(0, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), 1);
    end

    chk("protocol", 64'(proto_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
